// File: rtl/lj_pkg.sv
// rtl/lj_pkg.sv - shared fp32 field widths and types for the LJ force pipeline
package lj_pkg;

  localparam int FP32_W        = 32;
  localparam int FP32_SIGN_BIT = 31;
  localparam int FP32_MAG_W    = 31;

  typedef struct packed {
    logic                  sign;
    logic [FP32_MAG_W-1:0] mag;
  } fp32_t;

endpackage

// File: rtl/lj_fp32_abs_min.sv
// rtl/lj_fp32_abs_min.sv - fp32 absolute-value minimum, sign always taken from a
module lj_fp32_abs_min
  import lj_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output fp32_t min_val
);

  // Raw magnitude compare: NaN/Inf order by bit pattern, ties and +/-0 pick a.
  always_comb begin
    min_val.sign = a.sign;
    min_val.mag  = (a.mag <= b.mag) ? a.mag : b.mag;
  end

endmodule

// File: rtl/lj_rr_arbiter.sv
// rtl/lj_rr_arbiter.sv - round-robin grant search starting at ptr, one-hot plus index
module lj_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  int               k;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant_oh    = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    k           = 0;
    idx         = '0;
    for (int off = 0; off < N; off++) begin
      k = int'(ptr) + off;
      if (k >= N) k = k - N;
      idx = IDX_W'(k);
      if (!grant_valid && req[idx]) begin
        grant_valid   = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/lj_min_cmp_arbiter.sv
// rtl/lj_min_cmp_arbiter.sv - round-robin shared fp32 abs-min unit with 2-stage pipeline
module lj_min_cmp_arbiter
  import lj_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [FP32_W*NUM_REQ-1:0]   req_a,
  input  logic [FP32_W*NUM_REQ-1:0]   req_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [FP32_W-1:0]           out_min,
  output logic [ID_W-1:0]             out_id,
  output logic                        busy
);

  logic [NUM_REQ-1:0] grant_oh;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_valid;
  logic [ID_W-1:0]    rr_ptr;

  fp32_t              s1_a, s1_b, cmp_min, s2_min;
  logic [ID_W-1:0]    s1_id, s2_id;
  logic               s1_valid, s2_valid;
  logic               s1_to_s2, s1_en, accept;

  lj_rr_arbiter #(.N(NUM_REQ), .IDX_W(ID_W)) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .grant_oh    (grant_oh),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  lj_fp32_abs_min u_cmp (
    .a       (s1_a),
    .b       (s1_b),
    .min_val (cmp_min)
  );

  assign s1_to_s2  = s1_valid && (!s2_valid || out_ready);
  assign s1_en     = !s1_valid || s1_to_s2;
  // Gating on rst_n keeps req_ready low while the async reset is asserted.
  assign accept    = rst_n && s1_en && grant_valid;
  assign req_ready = accept ? grant_oh : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_min   <= '0;
      s2_id    <= '0;
      rr_ptr   <= '0;
    end else begin
      if (s1_to_s2) begin
        s2_min   <= cmp_min;
        s2_id    <= s1_id;
        s2_valid <= 1'b1;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
      if (s1_en) s1_valid <= accept;
      if (accept) begin
        s1_a   <= req_a[grant_idx*FP32_W +: FP32_W];
        s1_b   <= req_b[grant_idx*FP32_W +: FP32_W];
        s1_id  <= grant_idx;
        rr_ptr <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_min   = s2_min;
  assign out_id    = s2_id;
  assign busy      = s1_valid || s2_valid;

endmodule
